vdma_write_buffer_scheduler: RTL and testbench



---
 rtl/vdma_write_buffer_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_vdma_write_buffer_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdma_write_buffer_scheduler.sv
// Rotates the VDMA writer over a ring of frame buffers; param_addr settles 2 cycles after an acceptance, rd_ack 1 cycle after rd_req.
// No backpressure: the core paces acceptances via ctl_index and the reader is granted on every request not overlapping a pending ack.
module vdma_write_buffer_scheduler #(
    parameter int AXI4_ADDR_WIDTH = 32,
    parameter int INDEX_WIDTH     = 8,
    parameter int BUF_NUM         = 4,
    parameter int BUF_WIDTH       = 3
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       enable,
    input  logic [AXI4_ADDR_WIDTH-1:0] param_base,
    input  logic [AXI4_ADDR_WIDTH-1:0] param_frame_size,
    output logic                       busy,
    output logic [15:0]                frame_count,
    output logic                       core_ctl_enable,
    output logic                       core_ctl_update,
    output logic [AXI4_ADDR_WIDTH-1:0] core_param_addr,
    input  logic                       core_ctl_busy,
    input  logic [INDEX_WIDTH-1:0]     core_ctl_index,
    output logic [BUF_WIDTH-1:0]       wr_buf,
    input  logic                       rd_req,
    output logic                       rd_ack,
    output logic                       rd_valid,
    output logic                       rd_new,
    output logic [BUF_WIDTH-1:0]       rd_buf,
    output logic [AXI4_ADDR_WIDTH-1:0] rd_addr
);

    typedef enum logic [1:0] {IDLE, BUILD, RUN, STOP} state_t;

    state_t                     state;
    logic [AXI4_ADDR_WIDTH-1:0] size_l;
    logic [AXI4_ADDR_WIDTH-1:0] build_acc;
    logic [AXI4_ADDR_WIDTH-1:0] addr_tab [BUF_NUM];
    logic [BUF_WIDTH-1:0]       build_cnt;
    logic [BUF_WIDTH-1:0]       wr_cur;
    logic [BUF_WIDTH-1:0]       wr_next;
    logic [BUF_WIDTH-1:0]       latest;
    logic                       wr_cur_v;
    logic                       latest_v;
    logic                       rd_v;
    logic [INDEX_WIDTH-1:0]     prev_index;

    logic [BUF_WIDTH-1:0]       free_idx;
    logic                       free_found;
    logic                       taken;
    logic [AXI4_ADDR_WIDTH-1:0] wr_next_addr;
    logic [AXI4_ADDR_WIDTH-1:0] latest_addr;
    logic                       accept;
    logic                       grant;
    logic                       build_last;

    assign wr_buf     = wr_cur;
    assign rd_valid   = rd_v;
    assign accept     = ((state == RUN) || (state == STOP)) && (core_ctl_index != prev_index);
    assign grant      = rd_req && !rd_ack;
    assign build_last = (build_cnt == BUF_WIDTH'(BUF_NUM - 1));

    // Lowest buffer held by neither the writer, the newest frame nor the reader.
    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        taken      = 1'b0;
        for (int i = 0; i < BUF_NUM; i++) begin
            taken = (wr_cur_v && (wr_cur == BUF_WIDTH'(i))) ||
                    (latest_v && (latest == BUF_WIDTH'(i))) ||
                    (rd_v     && (rd_buf == BUF_WIDTH'(i)));
            if (!free_found && !taken) begin
                free_idx   = BUF_WIDTH'(i);
                free_found = 1'b1;
            end
        end
    end

    always_comb begin
        wr_next_addr = '0;
        latest_addr  = '0;
        for (int i = 0; i < BUF_NUM; i++) begin
            if (wr_next == BUF_WIDTH'(i)) wr_next_addr = addr_tab[i];
            if (latest == BUF_WIDTH'(i))  latest_addr  = addr_tab[i];
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state           <= IDLE;
            busy            <= 1'b0;
            frame_count     <= '0;
            core_ctl_enable <= 1'b0;
            core_ctl_update <= 1'b0;
            core_param_addr <= '0;
            size_l          <= '0;
            build_acc       <= '0;
            build_cnt       <= '0;
            wr_cur          <= '0;
            wr_next         <= '0;
            latest          <= '0;
            wr_cur_v        <= 1'b0;
            latest_v        <= 1'b0;
            rd_v            <= 1'b0;
            prev_index      <= '0;
            rd_ack          <= 1'b0;
            rd_new          <= 1'b0;
            rd_buf          <= '0;
            rd_addr         <= '0;
            for (int i = 0; i < BUF_NUM; i++) addr_tab[i] <= '0;
        end else begin
            wr_next <= free_idx;

            // Grant samples the pre-acceptance latest when both coincide.
            rd_ack <= grant;
            if (grant) begin
                if (latest_v) begin
                    rd_buf  <= latest;
                    rd_v    <= 1'b1;
                    rd_new  <= !rd_v || (rd_buf != latest);
                    rd_addr <= latest_addr;
                end else begin
                    rd_new  <= 1'b0;
                end
            end

            if (accept) begin
                prev_index <= core_ctl_index;
                if (wr_cur_v) begin
                    latest      <= wr_cur;
                    latest_v    <= 1'b1;
                    frame_count <= frame_count + 16'd1;
                end
                wr_cur   <= wr_next;
                wr_cur_v <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (enable) begin
                        size_l     <= param_frame_size;
                        build_acc  <= param_base;
                        build_cnt  <= '0;
                        wr_cur_v   <= 1'b0;
                        latest_v   <= 1'b0;
                        wr_next    <= '0;
                        prev_index <= core_ctl_index;
                        busy       <= 1'b1;
                        state      <= BUILD;
                    end
                end
                BUILD: begin
                    for (int i = 0; i < BUF_NUM; i++) begin
                        if (build_cnt == BUF_WIDTH'(i)) addr_tab[i] <= build_acc;
                    end
                    build_acc <= build_acc + size_l;
                    build_cnt <= build_cnt + BUF_WIDTH'(1);
                    if (build_last) begin
                        // wr_next is 0 or 1 here, whose entries are already written.
                        core_param_addr <= wr_next_addr;
                        core_ctl_enable <= 1'b1;
                        core_ctl_update <= 1'b1;
                        state           <= RUN;
                    end
                end
                RUN: begin
                    core_param_addr <= wr_next_addr;
                    if (!enable) begin
                        core_ctl_enable <= 1'b0;
                        core_ctl_update <= 1'b0;
                        state           <= STOP;
                    end
                end
                STOP: begin
                    core_param_addr <= wr_next_addr;
                    if (!core_ctl_busy) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vdma_write_buffer_scheduler.sv
// Randomised bench: a buffer-ring model predicts grants (scoreboard + monitor) and write-side state.
module tb_vdma_write_buffer_scheduler;

    localparam int AW = 32;
    localparam int IW = 8;
    localparam int BN = 4;
    localparam int BW = 3;

    logic          aclk = 1'b0;
    logic          areset;
    logic          enable;
    logic [AW-1:0] param_base;
    logic [AW-1:0] param_frame_size;
    logic          busy;
    logic [15:0]   frame_count;
    logic          core_ctl_enable;
    logic          core_ctl_update;
    logic [AW-1:0] core_param_addr;
    logic          core_ctl_busy;
    logic [IW-1:0] core_ctl_index;
    logic [BW-1:0] wr_buf;
    logic          rd_req;
    logic          rd_ack;
    logic          rd_valid;
    logic          rd_new;
    logic [BW-1:0] rd_buf;
    logic [AW-1:0] rd_addr;

    always #5 aclk = ~aclk;

    vdma_write_buffer_scheduler #(
        .AXI4_ADDR_WIDTH(AW), .INDEX_WIDTH(IW), .BUF_NUM(BN), .BUF_WIDTH(BW)
    ) dut (
        .aclk(aclk), .areset(areset), .enable(enable),
        .param_base(param_base), .param_frame_size(param_frame_size),
        .busy(busy), .frame_count(frame_count),
        .core_ctl_enable(core_ctl_enable), .core_ctl_update(core_ctl_update),
        .core_param_addr(core_param_addr), .core_ctl_busy(core_ctl_busy),
        .core_ctl_index(core_ctl_index), .wr_buf(wr_buf),
        .rd_req(rd_req), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_new(rd_new),
        .rd_buf(rd_buf), .rd_addr(rd_addr)
    );

    int errors = 0;
    int checks = 0;
    int ack_seen = 0;
    int ack_pushed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the ring as sets of owned buffers.
    int            m_wr_cur, m_latest, m_rd_buf, m_fc;
    bit            m_wr_cur_v, m_latest_v, m_rd_v;
    logic [AW-1:0] m_base, m_size, m_rd_addr;
    logic [IW-1:0] idx;

    typedef struct {
        bit            vld;
        bit            nw;
        int            buff;
        logic [AW-1:0] addr;
    } grant_t;
    grant_t rd_q[$];

    function automatic logic [AW-1:0] m_addr(input int i);
        return m_base + m_size * AW'(i);
    endfunction

    function automatic int m_free();
        for (int i = 0; i < BN; i++) begin
            if (!((m_wr_cur_v && m_wr_cur == i) || (m_latest_v && m_latest == i) ||
                  (m_rd_v && m_rd_buf == i)))
                return i;
        end
        return -1;
    endfunction

    task automatic m_grant();
        grant_t g;
        if (m_latest_v) begin
            g.nw      = !m_rd_v || (m_rd_buf != m_latest);
            m_rd_buf  = m_latest;
            m_rd_v    = 1'b1;
            m_rd_addr = m_addr(m_latest);
        end else begin
            g.nw = 1'b0;
        end
        g.vld  = m_rd_v;
        g.buff = m_rd_buf;
        g.addr = m_rd_addr;
        rd_q.push_back(g);
        ack_pushed++;
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_event(input bit with_rd);
        int n;
        n = m_free();
        if (with_rd) begin
            rd_req = 1'b1;
            m_grant();
        end
        if (m_wr_cur_v) begin
            m_latest   = m_wr_cur;
            m_latest_v = 1'b1;
            m_fc       = (m_fc + 1) & 16'hffff;
        end
        m_wr_cur   = n;
        m_wr_cur_v = 1'b1;
        idx            = idx + 8'd1;
        core_ctl_index = idx;
        tick();
        rd_req = 1'b0;
        ticks(2);
        chk("wr_buf", wr_buf, m_wr_cur);
        chk("frame_count", frame_count, m_fc);
        chk("param_addr", core_param_addr, m_addr(m_free()));
    endtask

    task automatic do_rd(input int hold);
        rd_req = 1'b1;
        m_grant();
        ticks(hold);
        rd_req = 1'b0;
        ticks(3);
    endtask

    task automatic start_run(input logic [AW-1:0] b, input logic [AW-1:0] s);
        int k;
        m_base = b;
        m_size = s;
        m_wr_cur_v = 1'b0;
        m_latest_v = 1'b0;
        param_base = b;
        param_frame_size = s;
        enable = 1'b1;
        k = 0;
        while (!core_ctl_enable && k < 40) begin
            tick();
            k++;
        end
        chk("run_reached", core_ctl_enable, 1'b1);
        chk("run_busy", busy, 1'b1);
        chk("run_update", core_ctl_update, 1'b1);
        chk("run_param_addr", core_param_addr, m_addr(m_free()));
        ticks(3);
    endtask

    always @(negedge aclk) begin : monitor
        grant_t g;
        if (!areset && rd_ack) begin
            ack_seen++;
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_ack: rd_ack=1 with no request outstanding");
            end else begin
                g = rd_q.pop_front();
                chk("rd_valid", rd_valid, g.vld);
                chk("rd_new", rd_new, g.nw);
                chk("rd_buf", rd_buf, g.buff);
                chk("rd_addr", rd_addr, g.addr);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, k;
        areset = 1'b1; enable = 1'b0; rd_req = 1'b0; core_ctl_busy = 1'b0;
        param_base = '0; param_frame_size = '0;
        idx = 8'h5a; core_ctl_index = idx;
        m_wr_cur = 0; m_latest = 0; m_rd_buf = 0; m_fc = 0;
        m_wr_cur_v = 0; m_latest_v = 0; m_rd_v = 0; m_rd_addr = '0;
        m_base = '0; m_size = '0;
        ticks(2);
        chk("rst_busy", busy, 0);
        chk("rst_fc", frame_count, 0);
        chk("rst_ctl_en", core_ctl_enable, 0);
        chk("rst_ctl_upd", core_ctl_update, 0);
        chk("rst_param", core_param_addr, 0);
        chk("rst_wr_buf", wr_buf, 0);
        chk("rst_rd", {rd_ack, rd_valid, rd_new, rd_buf}, 0);
        chk("rst_rd_addr", rd_addr, 0);
        areset = 1'b0;
        tick();

        do_rd(1);   // nothing completed yet: empty grant
        start_run(32'h1000_0000, 32'h0010_0000);

        for (int e = 0; e < 6; e++) begin
            do_event(1'b0);
            ticks($urandom_range(8, 30));
        end
        do_rd(1);
        do_rd(1);   // repeat without new frame
        do_rd(2);   // held request: second cycle overlaps ack

        for (int it = 0; it < 30; it++) begin
            r = $urandom_range(0, 3);
            case (r)
                0, 1: do_event(1'b0);
                2:    do_rd($urandom_range(1, 2));
                default: do_event(1'b1);
            endcase
            ticks($urandom_range(4, 20));
        end

        enable = 1'b0;
        core_ctl_busy = 1'b1;
        ticks(3);
        chk("stop_ctl_en", core_ctl_enable, 0);
        chk("stop_busy", busy, 1);
        do_event(1'b0);   // acceptance still tracked while stopping
        ticks(45);
        chk("stop_busy_held", busy, 1);
        core_ctl_busy = 1'b0;
        k = 0;
        while (busy && k < 10) begin
            tick();
            k++;
        end
        chk("idle_reached", busy, 0);
        ticks(3);

        // Ring crossing the top of the address space; reader lock survives restart.
        start_run(32'hfff0_0000, 32'h0010_0000);
        do_rd(1);
        for (int it = 0; it < 12; it++) begin
            r = $urandom_range(0, 3);
            case (r)
                0, 1: do_event(1'b0);
                2:    do_rd(1);
                default: do_event(1'b1);
            endcase
            ticks($urandom_range(4, 20));
        end
        ticks(3);
        chk("ack_count", ack_seen, ack_pushed);
        chk("rd_q_drained", rd_q.size(), 0);

        // Asynchronous reset between clock edges.
        @(posedge aclk);
        #3 areset = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_ctl_en", core_ctl_enable, 0);
        chk("arst_param", core_param_addr, 0);
        chk("arst_fc", frame_count, 0);
        chk("arst_rd", {rd_valid, rd_new, rd_buf, wr_buf}, 0);
        chk("arst_rd_addr", rd_addr, 0);
        ticks(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
